// File: rtl/obi_demux_pkg.sv
// Shared types and helpers for the OBI 1-to-2 address demultiplexer.
//   tgt_e        : decoded target of a request (SRAM, bridge, internal error)
//   *_DEF        : default decode windows
//   decode_addr  : address -> target, SRAM window wins on overlap
package obi_demux_pkg;

  typedef enum logic [1:0] {
    TGT_S0  = 2'd0,
    TGT_S1  = 2'd1,
    TGT_ERR = 2'd2
  } tgt_e;

  // Decode is done on a zero-extended copy so one function serves any
  // address width up to DEC_W.
  localparam int unsigned DEC_W = 64;

  localparam logic [31:0] S0_BASE_DEF = 32'h0000_0000;
  localparam logic [31:0] S0_MASK_DEF = 32'hFFFF_0000;
  localparam logic [31:0] S1_BASE_DEF = 32'h8000_0000;
  localparam logic [31:0] S1_MASK_DEF = 32'hFFF0_0000;

  function automatic tgt_e decode_addr(
    input logic [DEC_W-1:0] addr,
    input logic [DEC_W-1:0] s0_base,
    input logic [DEC_W-1:0] s0_mask,
    input logic [DEC_W-1:0] s1_base,
    input logic [DEC_W-1:0] s1_mask
  );
    tgt_e tgt;
    if ((addr & s0_mask) == s0_base) begin
      tgt = TGT_S0;
    end else if ((addr & s1_mask) == s1_base) begin
      tgt = TGT_S1;
    end else begin
      tgt = TGT_ERR;
    end
    return tgt;
  endfunction

endpackage

// File: rtl/obi_demux_err_slave.sv
// Internal error responder for unmapped addresses.
// Grants every request in the cycle it is presented and answers with an
// error response exactly one cycle later; back-to-back requests produce one
// response per cycle.
//   obi_clk_i, soc_rst_ni : clock, async active-low reset
//   req_i                 : request already qualified by the demux
//   gnt_o                 : grant (same cycle as req_i)
//   rvalid_o, err_o       : error response, one cycle after the handshake
module obi_err_slave (
  input  logic obi_clk_i,
  input  logic soc_rst_ni,
  input  logic req_i,
  output logic gnt_o,
  output logic rvalid_o,
  output logic err_o
);

  logic err_pend_d, err_pend_q;

  assign gnt_o = req_i;

  // Every request is a handshake, so the pending flag simply follows req_i.
  // A new handshake in the response cycle keeps it set for the next one.
  always_comb begin
    err_pend_d = req_i;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // values from before the edge, independent of block ordering.
  always_ff @(posedge obi_clk_i or negedge soc_rst_ni) begin
    if (!soc_rst_ni) begin
      err_pend_q <= 1'b0;
    end else begin
      err_pend_q <= err_pend_d;
    end
  end

  assign rvalid_o = err_pend_q;
  assign err_o    = err_pend_q;

endmodule

// File: rtl/obi_addr_demux.sv
// 1-to-2 OBI address demultiplexer: core data port -> SRAM (slave 0) and
// OBI-to-Wishbone bridge (slave 1). Unmapped addresses get an internal error
// response. Outstanding transactions all target one slave at a time, so
// responses come back in issue order without a reorder buffer.
//   m_*   : master side (request, grant, response)
//   s0_*  : SRAM slave port
//   s1_*  : bridge slave port
// Request fields (addr/wr_en/byte_en/wdata) go to both slaves unconditionally;
// only sN_req_o is steered.
module obi_addr_demux
  import obi_demux_pkg::*;
#(
  parameter int unsigned       ADDR_W  = 32,
  parameter int unsigned       DATA_W  = 32,
  parameter int unsigned       MAX_OUT = 4,
  parameter logic [ADDR_W-1:0] S0_BASE = S0_BASE_DEF,
  parameter logic [ADDR_W-1:0] S0_MASK = S0_MASK_DEF,
  parameter logic [ADDR_W-1:0] S1_BASE = S1_BASE_DEF,
  parameter logic [ADDR_W-1:0] S1_MASK = S1_MASK_DEF
) (
  input  logic                obi_clk_i,
  input  logic                soc_rst_ni,
  // master
  input  logic                m_req_i,
  output logic                m_gnt_o,
  input  logic [ADDR_W-1:0]   m_addr_i,
  input  logic                m_wr_en_i,
  input  logic [DATA_W/8-1:0] m_byte_en_i,
  input  logic [DATA_W-1:0]   m_wdata_i,
  output logic                m_rvalid_o,
  output logic [DATA_W-1:0]   m_rdata_o,
  output logic                m_err_o,
  // slave 0 (SRAM)
  output logic                s0_req_o,
  input  logic                s0_gnt_i,
  output logic [ADDR_W-1:0]   s0_addr_o,
  output logic                s0_wr_en_o,
  output logic [DATA_W/8-1:0] s0_byte_en_o,
  output logic [DATA_W-1:0]   s0_wdata_o,
  input  logic                s0_rvalid_i,
  input  logic [DATA_W-1:0]   s0_rdata_i,
  // slave 1 (bridge)
  output logic                s1_req_o,
  input  logic                s1_gnt_i,
  output logic [ADDR_W-1:0]   s1_addr_o,
  output logic                s1_wr_en_o,
  output logic [DATA_W/8-1:0] s1_byte_en_o,
  output logic [DATA_W-1:0]   s1_wdata_o,
  input  logic                s1_rvalid_i,
  input  logic [DATA_W-1:0]   s1_rdata_i
);

  localparam int unsigned     CNT_W   = $clog2(MAX_OUT) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUT);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  tgt_e             sel;
  tgt_e             cur_tgt_d, cur_tgt_q;
  logic [CNT_W-1:0] out_cnt_d, out_cnt_q;

  logic             resp;
  logic [DATA_W-1:0] rdata_mux;
  logic             err_mux;
  logic             allowed;
  logic             hs;
  logic             err_req, err_gnt, err_rvalid, err_err;

  assign sel = decode_addr(DEC_W'(m_addr_i),
                           DEC_W'(S0_BASE), DEC_W'(S0_MASK),
                           DEC_W'(S1_BASE), DEC_W'(S1_MASK));

  // Pass-through of request fields to both slaves.
  assign s0_addr_o    = m_addr_i;
  assign s0_wr_en_o   = m_wr_en_i;
  assign s0_byte_en_o = m_byte_en_i;
  assign s0_wdata_o   = m_wdata_i;
  assign s1_addr_o    = m_addr_i;
  assign s1_wr_en_o   = m_wr_en_i;
  assign s1_byte_en_o = m_byte_en_i;
  assign s1_wdata_o   = m_wdata_i;

  // Response path: only the current target is listened to, and only while
  // something is outstanding. Anything else is dropped.
  // NOTE: every signal written in this block gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    resp      = 1'b0;
    rdata_mux = '0;
    err_mux   = 1'b0;
    if (out_cnt_q != '0) begin
      unique case (cur_tgt_q)
        TGT_S0: begin
          resp      = s0_rvalid_i;
          rdata_mux = s0_rvalid_i ? s0_rdata_i : '0;
        end
        TGT_S1: begin
          resp      = s1_rvalid_i;
          rdata_mux = s1_rvalid_i ? s1_rdata_i : '0;
        end
        default: begin
          resp    = err_rvalid;
          err_mux = err_err;
        end
      endcase
    end
  end

  assign m_rvalid_o = resp;
  assign m_rdata_o  = rdata_mux;
  assign m_err_o    = err_mux;

  // Issue check. A response retiring in this cycle frees its slot, so the
  // last outstanding response lets a different target issue in the same
  // cycle and a full counter accepts a same-target request alongside it.
  always_comb begin
    logic idle;
    idle    = (out_cnt_q == '0) || ((out_cnt_q == CNT_ONE) && resp);
    allowed = idle || ((sel == cur_tgt_q) && ((out_cnt_q < CNT_MAX) || resp));
  end

  assign s0_req_o = m_req_i & allowed & (sel == TGT_S0);
  assign s1_req_o = m_req_i & allowed & (sel == TGT_S1);
  assign err_req  = m_req_i & allowed & (sel == TGT_ERR);

  always_comb begin
    m_gnt_o = 1'b0;
    unique case (sel)
      TGT_S0:  m_gnt_o = s0_gnt_i & allowed;
      TGT_S1:  m_gnt_o = s1_gnt_i & allowed;
      default: m_gnt_o = err_gnt;
    endcase
  end

  assign hs = m_req_i & m_gnt_o;

  obi_err_slave u_err_slave (
    .obi_clk_i  (obi_clk_i),
    .soc_rst_ni (soc_rst_ni),
    .req_i      (err_req),
    .gnt_o      (err_gnt),
    .rvalid_o   (err_rvalid),
    .err_o      (err_err)
  );

  always_comb begin
    cur_tgt_d = cur_tgt_q;
    out_cnt_d = out_cnt_q + CNT_W'(hs) - CNT_W'(resp);
    if (hs) begin
      cur_tgt_d = sel;
    end
  end

  always_ff @(posedge obi_clk_i or negedge soc_rst_ni) begin
    if (!soc_rst_ni) begin
      cur_tgt_q <= TGT_S0;
      out_cnt_q <= '0;
    end else begin
      cur_tgt_q <= cur_tgt_d;
      out_cnt_q <= out_cnt_d;
    end
  end

`ifndef SYNTHESIS
  // A slave answering when it has nothing outstanding points at a protocol
  // bug upstream; the response is discarded either way.
  logic s0_expected, s1_expected;
  assign s0_expected = (out_cnt_q != '0) && (cur_tgt_q == TGT_S0);
  assign s1_expected = (out_cnt_q != '0) && (cur_tgt_q == TGT_S1);

  a_s0_unexpected_rvalid : assert property (
    @(posedge obi_clk_i) disable iff (!soc_rst_ni) !(s0_rvalid_i && !s0_expected)
  ) else $warning("obi_addr_demux: dropped unexpected rvalid from slave 0");

  a_s1_unexpected_rvalid : assert property (
    @(posedge obi_clk_i) disable iff (!soc_rst_ni) !(s1_rvalid_i && !s1_expected)
  ) else $warning("obi_addr_demux: dropped unexpected rvalid from slave 1");
`endif

endmodule
